// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 8:1 multiplexer scan tester.
package mux_scan_pkg;

   localparam int NUM_CH      = 8;
   localparam int SEL_W       = 3;
   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SETTLE,
      S_SAMPLE,
      S_GAP,
      S_DONE
   } state_t;

   // Result of a set-bit search; wrap=1 means no qualifying bit was found.
   typedef struct packed {
      logic             wrap;
      logic [SEL_W-1:0] idx;
   } sel_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit synchronizer for the asynchronous DUT Y output, cleared by rst.
module sync_2ff
   import mux_scan_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sr_p0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_p0 <= '0;
      end else begin
         sr_p0 <= {sr_p0[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sr_p0[SYNC_STAGES-1];

endmodule

// File: rtl/mux_scan_tester.sv
// Scan controller that walks an external 8:1 mux over the enabled channels in a
// true-pattern and an inverted-pattern phase and records per-channel mismatches.
module mux_scan_tester
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int HOLD   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [NUM_CH-1:0] pattern,
   input  logic [NUM_CH-1:0] chan_mask,
   input  logic              y_in,
   output logic              dut_en,
   output logic [SEL_W-1:0]  dut_a,
   output logic [NUM_CH-1:0] dut_d,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [NUM_CH-1:0] fail_map
);

   // EN stays high for the settle window plus the synchronizer latency.
   localparam int SETTLE_CYC = SETTLE + SYNC_STAGES;
   localparam int TMR_MAX    = (SETTLE_CYC > HOLD) ? SETTLE_CYC : HOLD;
   localparam int TMR_W      = $clog2(TMR_MAX + 1);

   state_t            state;
   logic              phase;
   logic [SEL_W-1:0]  ch;
   logic [TMR_W-1:0]  tmr;
   logic [NUM_CH-1:0] pat_q;
   logic [NUM_CH-1:0] mask_q;
   logic              y_sync;
   logic [NUM_CH-1:0] pat_cur;
   sel_t              start_sel;
   sel_t              lo_sel;
   sel_t              up_sel;

   function automatic sel_t next_set(input logic [NUM_CH-1:0] mask,
                                     input logic [SEL_W-1:0]  cur,
                                     input logic              from_lsb);
      sel_t r;
      r.wrap = 1'b1;
      r.idx  = '0;
      // Descending scan so the lowest qualifying bit is the one that sticks.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (from_lsb || (i > int'(cur)))) begin
            r.wrap = 1'b0;
            r.idx  = SEL_W'(i);
         end
      end
      return r;
   endfunction

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (y_in),
      .q   (y_sync)
   );

   assign start_sel = next_set(chan_mask, '0, 1'b1);
   assign lo_sel    = next_set(mask_q, '0, 1'b1);
   assign up_sel    = next_set(mask_q, ch, 1'b0);
   assign pat_cur   = phase ? ~pat_q : pat_q;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         phase    <= 1'b0;
         ch       <= '0;
         tmr      <= '0;
         pat_q    <= '0;
         mask_q   <= '0;
         dut_en   <= 1'b0;
         dut_a    <= '0;
         dut_d    <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_map <= '0;
      end else begin
         done <= 1'b0;
         if (abort && (state != S_IDLE)) begin
            state  <= S_IDLE;
            dut_en <= 1'b0;
            pass   <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     pat_q    <= pattern;
                     mask_q   <= chan_mask;
                     fail_map <= '0;
                     pass     <= 1'b0;
                     phase    <= 1'b0;
                     if (!start_sel.wrap) begin
                        ch     <= start_sel.idx;
                        dut_a  <= start_sel.idx;
                        dut_d  <= pattern;
                        dut_en <= 1'b0;
                        state  <= S_SETUP;
                     end else begin
                        // Nothing to test: report an immediate clean pass.
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                     end
                  end
               end
               S_SETUP: begin
                  dut_en <= 1'b1;
                  tmr    <= '0;
                  state  <= S_SETTLE;
               end
               S_SETTLE: begin
                  if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
                     state <= S_SAMPLE;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end
               S_SAMPLE: begin
                  if (y_sync != dut_d[ch]) begin
                     fail_map[ch] <= 1'b1;
                  end
                  dut_en <= 1'b0;
                  tmr    <= '0;
                  state  <= S_GAP;
               end
               S_GAP: begin
                  if (tmr == TMR_W'(HOLD - 1)) begin
                     if (!up_sel.wrap) begin
                        ch    <= up_sel.idx;
                        dut_a <= up_sel.idx;
                        dut_d <= pat_cur;
                        state <= S_SETUP;
                     end else if (!phase) begin
                        phase <= 1'b1;
                        ch    <= lo_sel.idx;
                        dut_a <= lo_sel.idx;
                        dut_d <= ~pat_q;
                        state <= S_SETUP;
                     end else begin
                        // fail_map already includes the last sample (HOLD >= 1).
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (fail_map == '0);
                     end
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
